// File: rtl/sev_seg_scan_ctrl_if.sv
// Digit-write, mask-load and scan-output bundle for the seven-segment scanner.
// The master side is the register writer; the slave side is the scan controller.
interface sev_seg_scan_ctrl_if;
  logic       bEnable;
  logic       bWrValid;
  logic       bWrReady;
  logic [2:0] bWrAddr;
  logic [3:0] bWrData;
  logic       bWrDp;
  logic       bMaskWrValid;
  logic [7:0] bMaskData;
  logic [7:0] bDigitSel;
  logic [7:0] bSegmentOutput;
  logic [2:0] bScanIdx;
  logic       bFrameTick;

  modport master (
    output bEnable, bWrValid, bWrAddr, bWrData, bWrDp, bMaskWrValid, bMaskData,
    input  bWrReady, bDigitSel, bSegmentOutput, bScanIdx, bFrameTick
  );

  modport slave (
    input  bEnable, bWrValid, bWrAddr, bWrData, bWrDp, bMaskWrValid, bMaskData,
    output bWrReady, bDigitSel, bSegmentOutput, bScanIdx, bFrameTick
  );
endinterface

// File: rtl/sev_seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner: each slot is a dark blank phase followed by a show phase.
// All outputs registered; digit writes are always accepted outside reset (no backpressure).
module sev_seg_scan_ctrl #(
  parameter int CLKS_PER_DIGIT = 100000,
  parameter int BLANK_CLKS     = 1000
) (
  input logic            BrdClk,
  input logic            aReset,
  sev_seg_scan_ctrl_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_DIGIT);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CLKS - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLKS_PER_DIGIT - BLANK_CLKS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  typedef struct packed {
    logic [3:0] val;
    logic       dp;
    logic       en;
  } shadow_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      idx, idx_nxt;
  shadow_t         shadow, shadow_nxt;
  logic            tick_nxt, tick_q;
  logic [7:0]      sel_nxt, sel_q;
  logic [7:0]      seg_nxt, seg_q;
  logic            wr_ready;
  logic [7:0][3:0] dig_val;
  logic [7:0]      dig_dp;
  logic [7:0]      mask;

  function automatic logic [7:0] font(input logic [3:0] v);
    case (v)
      4'h0: font = 8'h03;  4'h1: font = 8'h9F;  4'h2: font = 8'h25;  4'h3: font = 8'h0D;
      4'h4: font = 8'h99;  4'h5: font = 8'h49;  4'h6: font = 8'h41;  4'h7: font = 8'h1F;
      4'h8: font = 8'h01;  4'h9: font = 8'h09;  4'hA: font = 8'h11;  4'hB: font = 8'hC1;
      4'hC: font = 8'h63;  4'hD: font = 8'h85;  4'hE: font = 8'h61;  default: font = 8'h71;
    endcase
  endfunction

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 1'b1;
    idx_nxt    = idx;
    shadow_nxt = shadow;
    tick_nxt   = 1'b0;
    if (!bus.bEnable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          tick_nxt  = 1'b1;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt  = SHOW;
            cnt_nxt    = '0;
            shadow_nxt = {dig_val[idx], dig_dp[idx], mask[idx]};
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            idx_nxt   = idx + 3'd1;
            tick_nxt  = (idx == 3'd7);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end

    // Outputs are computed from next-state values so the registered pins line up with the state.
    sel_nxt = 8'hFF;
    seg_nxt = 8'hFF;
    if (state_nxt == SHOW && shadow_nxt.en) begin
      sel_nxt = ~(8'h01 << idx_nxt);
      seg_nxt = font(shadow_nxt.val) & {7'h7F, ~shadow_nxt.dp};
    end
  end

  always_ff @(posedge BrdClk or posedge aReset) begin
    if (aReset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shadow   <= '0;
      tick_q   <= 1'b0;
      sel_q    <= 8'hFF;
      seg_q    <= 8'hFF;
      wr_ready <= 1'b0;
      dig_val  <= '0;
      dig_dp   <= '0;
      mask     <= 8'h01;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      shadow   <= shadow_nxt;
      tick_q   <= tick_nxt;
      sel_q    <= sel_nxt;
      seg_q    <= seg_nxt;
      wr_ready <= 1'b1;
      if (bus.bWrValid && wr_ready) begin
        dig_val[bus.bWrAddr] <= bus.bWrData;
        dig_dp[bus.bWrAddr]  <= bus.bWrDp;
      end
      if (bus.bMaskWrValid) begin
        mask <= bus.bMaskData;
      end
    end
  end

  assign bus.bWrReady       = wr_ready;
  assign bus.bDigitSel      = sel_q;
  assign bus.bSegmentOutput = seg_q;
  assign bus.bScanIdx       = idx;
  assign bus.bFrameTick     = tick_q;

endmodule
